// File: rtl/mem_responder.sv
// Word-addressed memory responder with valid/ready request and response channels,
// configurable wait-state latency, and alignment/range error reporting.
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, stateNext;
  logic [CNT_W-1:0]  cnt;
  logic              latWrite;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latWdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accessErr;
  logic              doAccess;
  logic [IDX_W-1:0]  memIdx;
  logic [31:0]       wordIdx;

  // Word index widened to 32 bits so the range check stays meaningful for any DEPTH.
  assign wordIdx   = 32'(latAddr[ADDR_W-1:2]);
  assign accessErr = (latAddr[1:0] != 2'b00) || (wordIdx >= 32'(DEPTH));
  assign memIdx    = IDX_W'(latAddr[ADDR_W-1:2]);
  assign doAccess  = (state == WAIT) && (cnt == '0);

  always_comb begin
    stateNext  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) stateNext = WAIT;
      end
      WAIT: begin
        if (cnt == '0) stateNext = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      latWrite   <= 1'b0;
      latAddr    <= '0;
      latWdata   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == IDLE && req_valid) begin
        latWrite <= req_write;
        latAddr  <= req_addr;
        latWdata <= req_wdata;
        cnt      <= CNT_W'(WAIT_CYCLES);
      end
      if (state == WAIT && cnt != '0) cnt <= cnt - CNT_W'(1);
      if (doAccess) begin
        resp_err   <= accessErr;
        resp_rdata <= (accessErr || latWrite) ? '0 : mem[memIdx];
      end
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (doAccess && latWrite && !accessErr) mem[memIdx] <= latWdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: three instances with different latency/depth,
// directed vector table, reset-mid-store sequence, and randomized traffic vs a model.
module tb_mem_responder;

  logic        clk;
  logic [2:0]  rstN, reqValid, reqWrite, respReady;
  logic [2:0]  reqReady, respValid, respErr, busyW;
  logic [9:0]  reqAddr   [3];
  logic [31:0] reqWdata  [3];
  logic [31:0] respRdata [3];

  int checks = 0;
  int errors = 0;
  int wc    [3] = '{2, 0, 3};
  int depth [3] = '{256, 256, 128};
  logic [31:0] mdl [3][256];

  mem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rstN[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
    .req_write(reqWrite[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
    .resp_valid(respValid[0]), .resp_ready(respReady[0]), .resp_rdata(respRdata[0]),
    .resp_err(respErr[0]), .busy(busyW[0]));

  mem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rstN[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
    .req_write(reqWrite[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
    .resp_valid(respValid[1]), .resp_ready(respReady[1]), .resp_rdata(respRdata[1]),
    .resp_err(respErr[1]), .busy(busyW[1]));

  mem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(128), .WAIT_CYCLES(3)) dut2 (
    .clk(clk), .rst_n(rstN[2]), .req_valid(reqValid[2]), .req_ready(reqReady[2]),
    .req_write(reqWrite[2]), .req_addr(reqAddr[2]), .req_wdata(reqWdata[2]),
    .resp_valid(respValid[2]), .resp_ready(respReady[2]), .resp_rdata(respRdata[2]),
    .resp_err(respErr[2]), .busy(busyW[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          d;
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: error rule, load value and store commit from plain arithmetic.
  task automatic predict(input int d, input logic wr, input logic [9:0] addr,
                         input logic [31:0] wdata, output logic [31:0] expData,
                         output logic expErr);
    int word;
    word    = int'(addr) / 4;
    expErr  = (int'(addr) % 4 != 0) || (word >= depth[d]);
    expData = (expErr || wr) ? 32'h0 : mdl[d][word];
    if (wr && !expErr) mdl[d][word] = wdata;
  endtask

  task automatic chkReset(input int d, input string tag);
    chk({tag, " req_ready"},  32'(reqReady[d]),  32'd1);
    chk({tag, " resp_valid"}, 32'(respValid[d]), 32'd0);
    chk({tag, " resp_rdata"}, respRdata[d],      32'd0);
    chk({tag, " resp_err"},   32'(respErr[d]),   32'd0);
    chk({tag, " busy"},       32'(busyW[d]),     32'd0);
  endtask

  // Starts and ends just after a falling edge.
  task automatic xact(input int d, input logic wr, input logic [9:0] addr,
                      input logic [31:0] wdata, input int delay,
                      input logic [31:0] expData, input logic expErr, input string tag);
    int n;
    chk({tag, " req_ready idle"}, 32'(reqReady[d]), 32'd1);
    reqValid[d] = 1'b1;
    reqWrite[d] = wr;
    reqAddr[d]  = addr;
    reqWdata[d] = wdata;
    @(negedge clk);
    reqValid[d] = 1'b0;
    chk({tag, " busy wait"},      32'(busyW[d]),    32'd1);
    chk({tag, " req_ready wait"}, 32'(reqReady[d]), 32'd0);
    n = 0;
    while (!respValid[d] && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(wc[d] + 1));
    chk({tag, " rdata"},   respRdata[d], expData);
    chk({tag, " err"},     32'(respErr[d]), 32'(expErr));
    for (int i = 0; i < delay; i++) begin
      if (i == 1) begin
        reqValid[d] = 1'b1;
        reqWrite[d] = 1'b1;
        reqAddr[d]  = 10'h010;
        reqWdata[d] = 32'hBAD0BAD0;
      end
      chk({tag, " req_ready resp"}, 32'(reqReady[d]), 32'd0);
      @(negedge clk);
      chk({tag, " hold valid"}, 32'(respValid[d]), 32'd1);
      chk({tag, " hold rdata"}, respRdata[d], expData);
      chk({tag, " hold err"},   32'(respErr[d]), 32'(expErr));
    end
    reqValid[d]  = 1'b0;
    respReady[d] = 1'b1;
    @(negedge clk);
    respReady[d] = 1'b0;
    chk({tag, " valid drop"}, 32'(respValid[d]), 32'd0);
    chk({tag, " idle ready"}, 32'(reqReady[d]),  32'd1);
    chk({tag, " idle busy"},  32'(busyW[d]),     32'd0);
  endtask

  initial begin
    logic [31:0] eData;
    logic        eErr;
    logic [9:0]  a;
    int          word, r;

    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 256; w++) mdl[d][w] = 32'h0;
    rstN = '0; reqValid = '0; reqWrite = '0; respReady = '0;
    for (int d = 0; d < 3; d++) begin
      reqAddr[d]  = '0;
      reqWdata[d] = '0;
    end

    #2;
    for (int d = 0; d < 3; d++) chkReset(d, $sformatf("reset%0d", d));
    @(negedge clk);
    rstN = '1;
    @(negedge clk);

    vecs.push_back('{0, 1'b1, 10'h010, 32'hDEADBEEF, 0, 32'h0,        1'b0});
    vecs.push_back('{0, 1'b0, 10'h010, 32'h0,        0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{0, 1'b1, 10'h012, 32'h00001234, 0, 32'h0,        1'b1});
    vecs.push_back('{0, 1'b0, 10'h010, 32'h0,        5, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{0, 1'b0, 10'h010, 32'h0,        0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{0, 1'b0, 10'h3FC, 32'h0,        0, 32'h0,        1'b0});
    vecs.push_back('{1, 1'b0, 10'h3FC, 32'h0,        0, 32'h0,        1'b0});
    vecs.push_back('{1, 1'b1, 10'h3FC, 32'hA5A5A5A5, 0, 32'h0,        1'b0});
    vecs.push_back('{1, 1'b0, 10'h3FC, 32'h0,        3, 32'hA5A5A5A5, 1'b0});
    vecs.push_back('{1, 1'b0, 10'h001, 32'h0,        0, 32'h0,        1'b1});
    vecs.push_back('{2, 1'b0, 10'h200, 32'h0,        0, 32'h0,        1'b1});
    vecs.push_back('{2, 1'b0, 10'h1FC, 32'h0,        0, 32'h0,        1'b0});
    vecs.push_back('{2, 1'b1, 10'h020, 32'h11112222, 0, 32'h0,        1'b0});
    vecs.push_back('{2, 1'b1, 10'h200, 32'h00005555, 0, 32'h0,        1'b1});
    vecs.push_back('{2, 1'b0, 10'h020, 32'h0,        2, 32'h11112222, 1'b0});

    foreach (vecs[i]) begin
      predict(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, eData, eErr);
      xact(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].delay,
           vecs[i].expData, vecs[i].expErr, $sformatf("vec%0d", i));
    end

    // Reset one cycle after accepting a store on the 3-wait-state instance.
    reqValid[2] = 1'b1;
    reqWrite[2] = 1'b1;
    reqAddr[2]  = 10'h020;
    reqWdata[2] = 32'hCAFEF00D;
    @(negedge clk);
    reqValid[2] = 1'b0;
    @(posedge clk);
    #1 rstN[2] = 1'b0;
    #1 chkReset(2, "midreset");
    @(negedge clk);
    rstN[2] = 1'b1;
    @(negedge clk);
    predict(2, 1'b0, 10'h020, 32'h0, eData, eErr);
    xact(2, 1'b0, 10'h020, 32'h0, 0, 32'h11112222, 1'b0, "after-reset load");

    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 40; k++) begin
        r = int'($urandom_range(0, 3));
        case (r)
          0:       word = int'($urandom_range(0, 7));
          1:       word = int'($urandom_range(124, 131));
          2:       word = int'($urandom_range(250, 255));
          default: word = int'($urandom_range(0, 255));
        endcase
        a = 10'(word * 4);
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        begin
          logic        wr;
          logic [31:0] wd;
          int          dl;
          wr = 1'($urandom_range(0, 1));
          wd = $urandom;
          dl = int'($urandom_range(0, 3));
          predict(d, wr, a, wd, eData, eErr);
          xact(d, wr, a, wd, dl, eData, eErr, $sformatf("rnd%0d.%0d", d, k));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
